// File: rtl/cs_arb_mux_5to1.sv
// Five-way packet-locked round-robin collector for one crossbar output port, with a
// single registered output stage. Define CS_ARB_LOCAL_PRIO_EN to give port L priority in IDLE.
module cs_arb_mux_5to1 #(
    parameter int unsigned DATA_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [5*DATA_W-1:0] data_i,
    input  logic [4:0]          valid_i,
    input  logic [4:0]          tail_i,
    output logic [4:0]          ready_o,
    output logic [DATA_W-1:0]   data_o,
    output logic                tail_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [2:0]          sel_o,
    output logic                busy_o
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;
    localparam logic [2:0] NO_SEL   = 3'b111;
    localparam logic [2:0] PORT_L   = 3'd4;

    logic [0:0]        r_state;
    logic [2:0]        r_grant;
    logic [2:0]        r_rr_ptr;
    logic [DATA_W-1:0] r_data;
    logic              r_tail;
    logic              r_valid;

    logic              w_can_acc;
    logic              w_found;
    logic [2:0]        w_winner;
    logic [4:0]        w_cand;
    logic [2:0]        w_port;
    logic              w_xfer;
    logic [DATA_W-1:0] w_in_data;
    logic              w_in_tail;

    assign w_can_acc = !r_valid || ready_i;

    // Cyclic scan starting one past the last winner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = NO_SEL;
`ifdef CS_ARB_LOCAL_PRIO_EN
        w_cand   = {1'b0, valid_i[3:0]};
`else
        w_cand   = valid_i;
`endif
        for (int i = 1; i <= 5; i++) begin
            if (!w_found && w_cand[3'((int'(r_rr_ptr) + i) % 5)]) begin
                w_found  = 1'b1;
                w_winner = 3'((int'(r_rr_ptr) + i) % 5);
            end
        end
`ifdef CS_ARB_LOCAL_PRIO_EN
        if (valid_i[4]) begin
            w_found  = 1'b1;
            w_winner = PORT_L;
        end
`endif
    end

    always_comb begin
        ready_o   = '0;
        sel_o     = NO_SEL;
        w_port    = NO_SEL;
        w_in_data = '0;
        w_in_tail = 1'b0;
        w_xfer    = 1'b0;
        if (r_state == S_LOCKED) begin
            w_port = r_grant;
            sel_o  = r_grant;
        end else if (w_found) begin
            w_port = w_winner;
            sel_o  = w_winner;
        end
        for (int k = 0; k < 5; k++) begin
            if (w_port == 3'(k)) begin
                ready_o[k] = w_can_acc;
                w_in_data  = data_i[k*DATA_W +: DATA_W];
                w_in_tail  = tail_i[k];
                w_xfer     = w_can_acc && valid_i[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_grant  <= NO_SEL;
            r_rr_ptr <= PORT_L;
            r_data   <= '0;
            r_tail   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_data  <= w_in_data;
                r_tail  <= w_in_tail;
                r_valid <= 1'b1;
            end else if (ready_i) begin
                r_valid <= 1'b0;
            end

            if (w_xfer) begin
                if (r_state == S_IDLE) begin
`ifdef CS_ARB_LOCAL_PRIO_EN
                    if (w_port != PORT_L) begin
                        r_rr_ptr <= w_port;
                    end
`else
                    r_rr_ptr <= w_port;
`endif
                    if (!w_in_tail) begin
                        r_state <= S_LOCKED;
                        r_grant <= w_port;
                    end
                end else if (w_in_tail) begin
                    r_state <= S_IDLE;
                    r_grant <= NO_SEL;
                end
            end
        end
    end

    assign data_o  = r_data;
    assign tail_o  = r_tail;
    assign valid_o = r_valid;
    assign busy_o  = (r_state == S_LOCKED);

endmodule

// File: tb/tb_cs_arb_mux_5to1.sv
// Scoreboard bench for cs_arb_mux_5to1: per-port packet sources, a packet-level arbitration
// model predicting grants, and a monitor comparing every accepted output flit.
module tb_cs_arb_mux_5to1;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] d;
        logic         t;
    } flit_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [5*W-1:0] data_i;
    logic [4:0]     valid_i;
    logic [4:0]     tail_i;
    logic [4:0]     ready_o;
    logic [W-1:0]   data_o;
    logic           tail_o;
    logic           valid_o;
    logic           ready_i;
    logic [2:0]     sel_o;
    logic           busy_o;

    cs_arb_mux_5to1 #(.DATA_W(W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .tail_i  (tail_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .tail_o  (tail_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .sel_o   (sel_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    flit_t src_q [5][$];
    flit_t exp_q [$];
    int    seq [5];
    int    vectors = 0;
    int    miscompares = 0;

    // Model state: which packet owns the link, last round-robin winner, output register full.
    bit    m_locked;
    int    m_grant;
    int    m_rr;
    bit    m_outv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [4:0] v);
        logic [4:0] c;
        c = v;
`ifdef CS_ARB_LOCAL_PRIO_EN
        if (c[4]) return 4;
        c[4] = 1'b0;
`endif
        for (int i = 1; i <= 5; i++) begin
            int p;
            p = (m_rr + i) % 5;
            if (c[p]) return p;
        end
        return -1;
    endfunction

    task automatic push_pkt(input int k, input int len, input logic [W-1:0] base);
        for (int i = 0; i < len; i++) begin
            flit_t f;
            f.d = (base != '0) ? base + W'(i) : {3'(k), 13'(seq[k])};
            f.t = (i == len - 1);
            seq[k]++;
            src_q[k].push_back(f);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_grant  = -1;
        m_rr     = 4;
        m_outv   = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 5; k++) src_q[k].delete();
    endtask

    task automatic check_cycle();
        logic [4:0] er;
        int         es;
        int         w;
        int         k;
        bit         can;
        can = !m_outv || ready_i;
        er  = '0;
        es  = 7;
        if (m_locked) begin
            es = m_grant;
            if (can) er[m_grant] = 1'b1;
        end else begin
            w = pick(valid_i);
            if (w >= 0) begin
                es = w;
                if (can) er[w] = 1'b1;
            end
        end
        chk("ready_o", 32'(ready_o), 32'(er));
        chk("sel_o", 32'(sel_o), 32'(es));
        chk("busy_o", 32'(busy_o), 32'(m_locked));
        chk("valid_o", 32'(valid_o), 32'(m_outv));
        k = -1;
        for (int p = 0; p < 5; p++) if (er[p] && valid_i[p]) k = p;
        if (k >= 0) begin
            flit_t f;
            f = src_q[k].pop_front();
            exp_q.push_back(f);
            if (!m_locked) begin
`ifdef CS_ARB_LOCAL_PRIO_EN
                if (k != 4) m_rr = k;
`else
                m_rr = k;
`endif
                if (!f.t) begin
                    m_locked = 1'b1;
                    m_grant  = k;
                end
            end else if (f.t) begin
                m_locked = 1'b0;
                m_grant  = -1;
            end
            m_outv = 1'b1;
        end else if (ready_i) begin
            m_outv = 1'b0;
        end
    endtask

    task automatic step(input int pv, input int pr);
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            if (src_q[k].size() > 0 && int'($urandom_range(99)) < pv) begin
                valid_i[k]       = 1'b1;
                data_i[k*W +: W] = src_q[k][0].d;
                tail_i[k]        = src_q[k][0].t;
            end else begin
                valid_i[k]       = 1'b0;
                data_i[k*W +: W] = W'($urandom);
                tail_i[k]        = 1'($urandom);
            end
        end
        ready_i = (int'($urandom_range(99)) < pr);
        #3;
        check_cycle();
    endtask

    // Reset lands on the next edge with whatever inputs are currently driven.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        valid_i = '0;
        ready_i = 1'b1;
        #3;
        chk("rst valid_o", 32'(valid_o), 32'd0);
        chk("rst busy_o", 32'(busy_o), 32'd0);
        chk("rst sel_o", 32'(sel_o), 32'd7);
        chk("rst ready_o", 32'(ready_o), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected flit", 32'(data_o), 32'hFFFF_FFFF);
            end else begin
                flit_t f;
                f = exp_q.pop_front();
                chk("data_o", 32'(data_o), 32'(f.d));
                chk("tail_o", 32'(tail_o), 32'(f.t));
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        valid_i = '0;
        tail_i  = '0;
        data_i  = '0;
        ready_i = 1'b0;
        for (int k = 0; k < 5; k++) seq[k] = 1;
        model_reset();
        do_reset();

        // Single-flit packet on S.
        push_pkt(1, 1, 16'hA5A5);
        step(100, 100);
        step(0, 100);

        // All five ports, single-flit packets, full throughput.
        for (int k = 0; k < 5; k++) push_pkt(k, 1, '0);
        for (int k = 0; k < 5; k++) push_pkt(k, 1, '0);
        repeat (11) step(100, 100);

        // Three-flit packet on W while E waits.
        push_pkt(2, 3, 16'h0001);
        push_pkt(3, 1, '0);
        repeat (5) step(100, 100);

        // Backpressure hold for four cycles.
        push_pkt(0, 2, '0);
        push_pkt(4, 1, '0);
        step(100, 100);
        repeat (4) step(100, 0);
        repeat (5) step(100, 100);

        // Reset during the second flit of a locked packet on N.
        push_pkt(0, 3, '0);
        step(100, 100);
        do_reset();
        push_pkt(1, 1, '0);
        push_pkt(0, 1, '0);
        step(100, 100);
        chk("post-reset first grant", 32'(sel_o), 32'd0);
        repeat (3) step(100, 100);

`ifdef CS_ARB_LOCAL_PRIO_EN
        push_pkt(1, 2, '0);
        push_pkt(4, 1, '0);
        step(100, 100);
        repeat (3) step(100, 100);
        push_pkt(1, 3, '0);
        step(100, 100);
        push_pkt(4, 1, '0);
        repeat (5) step(100, 100);
`endif

        // Randomised traffic with random bubbles and backpressure.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 5; k++) begin
                if (src_q[k].size() < 2 && $urandom_range(3) == 0)
                    push_pkt(k, 1 + int'($urandom_range(3)), '0);
            end
            step(70, 70);
        end

        // Drain sources and the output stage, with a bounded cycle budget.
        for (int c = 0; c < 300; c++) begin
            if (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()
                + src_q[4].size() == 0) break;
            step(100, 100);
        end
        repeat (2) step(100, 100);
        chk("sources drained", 32'(src_q[0].size() + src_q[1].size() + src_q[2].size()
            + src_q[3].size() + src_q[4].size()), 32'd0);
        chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
